// File: rtl/period_sequencer.sv
// Table-driven sequencer for a programmable clock divider: walks a table of
// (period, repeat count) entries and retunes o_clk only at output-cycle boundaries.
module period_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int PW    = 32,
  parameter int CW    = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [PW-1:0] i_wr_period,
  input  logic [CW-1:0] i_wr_reps,
  input  logic [AW-1:0] i_last_addr,
  input  logic          i_loop,
  input  logic          i_start,
  input  logic          i_stop,
  output logic          o_clk,
  output logic          o_busy,
  output logic [AW-1:0] o_index,
  output logic          o_step,
  output logic          o_done,
  output logic          o_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [PW-1:0] tbl_per_q  [DEPTH];
  logic [PW-1:0] tbl_per_d  [DEPTH];
  logic [CW-1:0] tbl_reps_q [DEPTH];
  logic [CW-1:0] tbl_reps_d [DEPTH];

  // Table storage is cleared by reset, so it lives in flops rather than RAM.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tbl
    always_comb begin
      tbl_per_d[gi]  = tbl_per_q[gi];
      tbl_reps_d[gi] = tbl_reps_q[gi];
      if (i_wr_en && (i_wr_addr == AW'(gi))) begin
        tbl_per_d[gi]  = i_wr_period;
        tbl_reps_d[gi] = i_wr_reps;
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        tbl_per_q[gi]  <= '0;
        tbl_reps_q[gi] <= '0;
      end else begin
        tbl_per_q[gi]  <= tbl_per_d[gi];
        tbl_reps_q[gi] <= tbl_reps_d[gi];
      end
    end
  end

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] last_q, last_d;
  logic          loop_q, loop_d;
  logic [PW-1:0] per_q, per_d;
  logic [CW-1:0] reps_q, reps_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rep_q, rep_d;
  logic          clk_q, clk_d;
  logic          step_q, step_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [PW-1:0] half;
  logic [CW-1:0] reps_eff;
  logic          last_rep;

  // Odd periods lose their extra cycle; a zero repeat count still runs once.
  assign half     = per_q >> 1;
  assign reps_eff = (reps_q == '0) ? CW'(1) : reps_q;
  assign last_rep = (rep_q == reps_eff - CW'(1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    loop_d  = loop_q;
    per_d   = per_q;
    reps_d  = reps_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    clk_d   = clk_q;
    step_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        clk_d = 1'b0;
        if (i_start && !i_stop) begin
          last_d  = i_last_addr;
          loop_d  = i_loop;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        clk_d = 1'b0;
        if (i_stop) begin
          state_d = ST_IDLE;
        end else begin
          per_d  = tbl_per_q[idx_q];
          reps_d = tbl_reps_q[idx_q];
          cnt_d  = '0;
          rep_d  = '0;
          if (tbl_per_q[idx_q] < PW'(2)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (i_stop) begin
          // Abrupt abort: o_clk is forced low even in the middle of a high phase.
          clk_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q == half - PW'(1)) begin
          cnt_d = '0;
          clk_d = !clk_q;
          if (clk_q) begin
            if (last_rep) begin
              step_d = 1'b1;
              if (idx_q == last_q) begin
                if (loop_q) begin
                  idx_d   = '0;
                  state_d = ST_LOAD;
                end else begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
                end
              end else begin
                idx_d   = idx_q + AW'(1);
                state_d = ST_LOAD;
              end
            end else begin
              rep_d = rep_q + CW'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + PW'(1);
        end
      end

      default: begin
        clk_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      loop_q  <= 1'b0;
      per_q   <= '0;
      reps_q  <= '0;
      cnt_q   <= '0;
      rep_q   <= '0;
      clk_q   <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      loop_q  <= loop_d;
      per_q   <= per_d;
      reps_q  <= reps_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      clk_q   <= clk_d;
      step_q  <= step_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_clk   = clk_q;
  assign o_busy  = (state_q != ST_IDLE);
  assign o_index = idx_q;
  assign o_step  = step_q;
  assign o_done  = done_q;
  assign o_err   = err_q;

endmodule
